// File: rtl/mem_bus_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_ctl_pkg
// Brief    : Shared typedefs and width constants for the memory bus stage.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_ctl_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        MB_IDLE = 2'd0,
        MB_REQ  = 2'd1,
        MB_ERR  = 2'd2
    } mem_state_t;

    // Smallest counter width able to hold t-1 (at least one bit).
    function automatic int cnt_w(input int t);
        return (t > 1) ? $clog2(t) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_ctl_if
// Brief    : CPU-side strobes and external memory request/ack bus bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_bus_ctl_if #(
    parameter int AW = mem_bus_ctl_pkg::ADDR_W,
    parameter int DW = mem_bus_ctl_pkg::DATA_W
);
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          cpu_en;
    logic [DW-1:0] data_out;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;
    logic          bus_err;

    // The controller serves CPU requests and drives the memory bus.
    modport slave (
        input  mem_rd, mem_wr, addr, wdata, bus_ack, bus_rdata,
        output cpu_en, data_out, bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );

    modport master (
        output mem_rd, mem_wr, addr, wdata, bus_ack, bus_rdata,
        input  cpu_en, data_out, bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_req_detect.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_detect
// Brief    : Turns level-style rd/wr strobes into a single-cycle start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_detect
    import mem_bus_ctl_pkg::*;
#(
    parameter int AW = ADDR_W
) (
    input  wire logic          clk,
    input  wire logic          rst_,
    input  wire logic          i_mem_rd,
    input  wire logic          i_mem_wr,
    input  wire logic [AW-1:0] i_addr,
    output logic               o_start
);
    logic          w_req_now;
    logic          r_req_prev;
    logic [AW-1:0] r_addr_prev;
    logic          r_wr_prev;

    assign w_req_now = i_mem_rd | i_mem_wr;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_req_prev  <= 1'b0;
            r_addr_prev <= '0;
            r_wr_prev   <= 1'b0;
        end else begin
            r_req_prev  <= w_req_now;
            r_addr_prev <= i_addr;
            r_wr_prev   <= i_mem_wr;
        end
    end

    // A new request is a rising strobe or a change of address/direction.
    assign o_start = w_req_now &
                     (~r_req_prev | (i_addr != r_addr_prev) | (i_mem_wr != r_wr_prev));
endmodule
`default_nettype wire

// File: rtl/mem_bus_ctl.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_ctl
// Brief    : Strobe-to-req/ack bus bridge with CPU freeze, timeout and error.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_ctl
    import mem_bus_ctl_pkg::*;
#(
    parameter int AW      = ADDR_W,
    parameter int DW      = DATA_W,
    parameter int TIMEOUT = 16
) (
    input  wire logic     clk,
    input  wire logic     rst_,
    mem_bus_ctl_if.slave  bus
);
    localparam int CW = cnt_w(TIMEOUT);

    mem_state_t    r_state;
    logic [CW-1:0] r_wait_cnt;
    logic          r_bus_req;
    logic          r_bus_we;
    logic [AW-1:0] r_bus_addr;
    logic [DW-1:0] r_bus_wdata;
    logic [DW-1:0] r_data_out;
    logic          r_bus_err;
    logic          w_start;

    mem_req_detect #(
        .AW(AW)
    ) u_req_detect (
        .clk      (clk),
        .rst_     (rst_),
        .i_mem_rd (bus.mem_rd),
        .i_mem_wr (bus.mem_wr),
        .i_addr   (bus.addr),
        .o_start  (w_start)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state     <= MB_IDLE;
            r_wait_cnt  <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_data_out  <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                MB_IDLE: begin
                    if (w_start) begin
                        if (bus.mem_rd && bus.mem_wr) begin
                            r_bus_err <= 1'b1;
                            r_state   <= MB_ERR;
                        end else begin
                            r_bus_addr  <= bus.addr;
                            r_bus_we    <= bus.mem_wr;
                            r_bus_wdata <= bus.wdata;
                            r_bus_req   <= 1'b1;
                            r_wait_cnt  <= '0;
                            r_state     <= MB_REQ;
                        end
                    end
                end
                MB_REQ: begin
                    if (bus.bus_ack) begin
                        r_bus_req <= 1'b0;
                        if (!r_bus_we) begin
                            r_data_out <= bus.bus_rdata;
                        end
                        r_state <= MB_IDLE;
                    end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= MB_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                MB_ERR: begin
                    r_bus_req <= 1'b0;
                    r_bus_err <= 1'b1;
                end
                default: begin
                    r_state <= MB_IDLE;
                end
            endcase
        end
    end

    // Freeze the CPU in the very cycle a new request appears.
    assign bus.cpu_en    = (r_state == MB_IDLE) && !w_start;
    assign bus.data_out  = r_data_out;
    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wdata = r_bus_wdata;
    assign bus.bus_err   = r_bus_err;
endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_ctl
// Brief    : Directed self-checking bench for mem_bus_ctl (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctl;
    import mem_bus_ctl_pkg::*;

    logic clk;
    logic rst_;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   req_rises = 0;
    logic req_seen_prev = 1'b0;

    mem_bus_ctl_if #(.AW(5), .DW(8)) bus ();

    mem_bus_ctl #(
        .AW      (5),
        .DW      (8),
        .TIMEOUT (4)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.bus_req === 1'b1 && req_seen_prev !== 1'b1) req_rises++;
        req_seen_prev = bus.bus_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_cycle();
        @(negedge clk);
        bus.mem_rd  = 1'b0;
        bus.mem_wr  = 1'b0;
        bus.bus_ack = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
        rst_       = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        #1;
    endtask

    // Drives one strobe, plays memory (ack in REQ cycle ack_k, 0 = never) and
    // returns at the first cycle cpu_en is back high, or after max_c cycles.
    task automatic run_txn(input logic rd, input logic wr, input logic [4:0] a,
                           input logic [7:0] wd, input int ack_k, input logic [7:0] rdat,
                           input int max_c, output int en_low, output int req_hi,
                           output logic [4:0] s_addr, output logic s_we,
                           output logic [7:0] s_wdata, output logic stable,
                           output logic done);
        en_low = 0; req_hi = 0; done = 1'b0; stable = 1'b1;
        s_addr = '0; s_we = 1'b0; s_wdata = '0;
        @(negedge clk);
        bus.mem_rd = rd; bus.mem_wr = wr; bus.addr = a; bus.wdata = wd;
        for (int c = 0; c < max_c; c++) begin
            if (c > 0) @(negedge clk);
            bus.bus_ack   = (bus.bus_req === 1'b1) && (req_hi + 1 == ack_k);
            bus.bus_rdata = rdat;
            #1;
            if (bus.bus_req === 1'b1) begin
                if (req_hi == 0) begin
                    s_addr = bus.bus_addr; s_we = bus.bus_we; s_wdata = bus.bus_wdata;
                end else if (bus.bus_addr !== s_addr || bus.bus_we !== s_we ||
                             bus.bus_wdata !== s_wdata) begin
                    stable = 1'b0;
                end
                req_hi++;
            end
            if (bus.cpu_en !== 1'b1) begin
                en_low++;
            end else begin
                done = 1'b1;
                break;
            end
        end
        bus.bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus.bus_ack = 1'b0; bus.bus_rdata = '0;
        #3;
        n_checks++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_bus_req: got %b want 0", bus.bus_req); end
        n_checks++; if (bus.bus_we !== 1'b0) begin n_fail++; $display("FAIL rst_bus_we: got %b want 0", bus.bus_we); end
        n_checks++; if (bus.bus_addr !== 5'h00) begin n_fail++; $display("FAIL rst_bus_addr: got %h want 00", bus.bus_addr); end
        n_checks++; if (bus.bus_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_bus_wdata: got %h want 00", bus.bus_wdata); end
        n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data_out: got %h want 00", bus.data_out); end
        n_checks++; if (bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_bus_err: got %b want 0", bus.bus_err); end
        n_checks++; if (bus.cpu_en !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_en: got %b want 1", bus.cpu_en); end
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_wait_read();
        int en_low, req_hi; logic [4:0] sa; logic swe, stb, dn; logic [7:0] swd;
        run_txn(1'b1, 1'b0, 5'h03, 8'h00, 1, 8'hA5, 20, en_low, req_hi, sa, swe, swd, stb, dn);
        n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL zw_done: got %b want 1", dn); end
        n_checks++; if (en_low != 2) begin n_fail++; $display("FAIL zw_cpu_en_low: got %0d want 2", en_low); end
        n_checks++; if (req_hi != 1) begin n_fail++; $display("FAIL zw_req_cycles: got %0d want 1", req_hi); end
        n_checks++; if (sa !== 5'h03) begin n_fail++; $display("FAIL zw_bus_addr: got %h want 03", sa); end
        n_checks++; if (swe !== 1'b0) begin n_fail++; $display("FAIL zw_bus_we: got %b want 0", swe); end
        n_checks++; if (bus.data_out !== 8'hA5) begin n_fail++; $display("FAIL zw_data_out: got %h want a5", bus.data_out); end
        idle_cycle();
    endtask

    task automatic test_wait_write();
        int en_low, req_hi; logic [4:0] sa; logic swe, stb, dn; logic [7:0] swd;
        run_txn(1'b0, 1'b1, 5'h1F, 8'h3C, 3, 8'h77, 20, en_low, req_hi, sa, swe, swd, stb, dn);
        n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL ww_done: got %b want 1", dn); end
        n_checks++; if (req_hi != 3) begin n_fail++; $display("FAIL ww_req_cycles: got %0d want 3", req_hi); end
        n_checks++; if (en_low != 4) begin n_fail++; $display("FAIL ww_cpu_en_low: got %0d want 4", en_low); end
        n_checks++; if (swe !== 1'b1) begin n_fail++; $display("FAIL ww_bus_we: got %b want 1", swe); end
        n_checks++; if (swd !== 8'h3C) begin n_fail++; $display("FAIL ww_bus_wdata: got %h want 3c", swd); end
        n_checks++; if (sa !== 5'h1F) begin n_fail++; $display("FAIL ww_bus_addr: got %h want 1f", sa); end
        n_checks++; if (stb !== 1'b1) begin n_fail++; $display("FAIL ww_bus_stable: got %b want 1", stb); end
        n_checks++; if (bus.data_out !== 8'hA5) begin n_fail++; $display("FAIL ww_data_out: got %h want a5", bus.data_out); end
        idle_cycle();
    endtask

    task automatic test_ack_outside_req();
        @(negedge clk);
        bus.bus_ack = 1'b1; bus.bus_rdata = 8'h11;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        #1;
        n_checks++; if (bus.data_out !== 8'hA5) begin n_fail++; $display("FAIL stray_ack_data_out: got %h want a5", bus.data_out); end
        n_checks++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL stray_ack_bus_req: got %b want 0", bus.bus_req); end
        n_checks++; if (bus.cpu_en !== 1'b1) begin n_fail++; $display("FAIL stray_ack_cpu_en: got %b want 1", bus.cpu_en); end
    endtask

    task automatic test_held_strobe();
        int en_low, req_hi, r0; logic [4:0] sa1, sa2; logic swe, stb, dn1, dn2; logic [7:0] swd;
        r0 = req_rises;
        run_txn(1'b1, 1'b0, 5'h02, 8'h00, 1, 8'h5A, 20, en_low, req_hi, sa1, swe, swd, stb, dn1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_checks++; if (bus.cpu_en !== 1'b1 || bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL held_no_restart: cpu_en %b bus_req %b want 1 0", bus.cpu_en, bus.bus_req); end
        end
        idle_cycle();
        idle_cycle();
        run_txn(1'b1, 1'b0, 5'h10, 8'h00, 2, 8'hC3, 20, en_low, req_hi, sa2, swe, swd, stb, dn2);
        n_checks++; if (dn1 !== 1'b1 || dn2 !== 1'b1) begin n_fail++; $display("FAIL held_done: got %b %b want 1 1", dn1, dn2); end
        n_checks++; if (req_rises - r0 != 2) begin n_fail++; $display("FAIL held_req_pulses: got %0d want 2", req_rises - r0); end
        n_checks++; if (sa1 !== 5'h02) begin n_fail++; $display("FAIL held_addr1: got %h want 02", sa1); end
        n_checks++; if (sa2 !== 5'h10) begin n_fail++; $display("FAIL held_addr2: got %h want 10", sa2); end
        n_checks++; if (bus.data_out !== 8'hC3) begin n_fail++; $display("FAIL held_data_out: got %h want c3", bus.data_out); end
        idle_cycle();
    endtask

    task automatic test_protocol_error();
        idle_cycle(); #1;
        n_checks++; if (bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL perr_pre_err: got %b want 0", bus.bus_err); end
        @(negedge clk);
        bus.mem_rd = 1'b1; bus.mem_wr = 1'b1; bus.addr = 5'h05;
        #1;
        n_checks++; if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL perr_cpu_en_now: got %b want 0", bus.cpu_en); end
        @(negedge clk); #1;
        n_checks++; if (bus.bus_err !== 1'b1) begin n_fail++; $display("FAIL perr_bus_err: got %b want 1", bus.bus_err); end
        n_checks++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL perr_bus_req: got %b want 0", bus.bus_req); end
        n_checks++; if (dut.r_state !== MB_ERR) begin n_fail++; $display("FAIL perr_state: got %0d want %0d", dut.r_state, MB_ERR); end
        idle_cycle();
        idle_cycle(); #1;
        n_checks++; if (bus.cpu_en !== 1'b0 || bus.bus_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: cpu_en %b bus_err %b want 0 1", bus.cpu_en, bus.bus_err); end
        reset_pulse();
        n_checks++; if (bus.cpu_en !== 1'b1 || bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL perr_after_rst: cpu_en %b bus_err %b want 1 0", bus.cpu_en, bus.bus_err); end
    endtask

    task automatic test_timeout();
        int en_low, req_hi; logic [4:0] sa; logic swe, stb, dn; logic [7:0] swd;
        run_txn(1'b1, 1'b0, 5'h04, 8'h00, 0, 8'h00, 8, en_low, req_hi, sa, swe, swd, stb, dn);
        n_checks++; if (dn !== 1'b0) begin n_fail++; $display("FAIL to_cpu_resumed: got %b want 0", dn); end
        n_checks++; if (req_hi != 4) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 4", req_hi); end
        n_checks++; if (en_low != 8) begin n_fail++; $display("FAIL to_cpu_en_low: got %0d want 8", en_low); end
        n_checks++; if (bus.bus_err !== 1'b1) begin n_fail++; $display("FAIL to_bus_err: got %b want 1", bus.bus_err); end
        n_checks++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL to_bus_req: got %b want 0", bus.bus_req); end
        for (int i = 0; i < 3; i++) idle_cycle();
        #1;
        n_checks++; if (bus.cpu_en !== 1'b0 || bus.bus_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: cpu_en %b bus_err %b want 0 1", bus.cpu_en, bus.bus_err); end
        reset_pulse();
        n_checks++; if (bus.cpu_en !== 1'b1 || bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL to_after_rst: cpu_en %b bus_err %b want 1 0", bus.cpu_en, bus.bus_err); end
    endtask

    task automatic test_reset_mid_txn();
        int en_low, req_hi; logic [4:0] sa; logic swe, stb, dn; logic [7:0] swd;
        run_txn(1'b1, 1'b0, 5'h01, 8'h00, 1, 8'h99, 20, en_low, req_hi, sa, swe, swd, stb, dn);
        n_checks++; if (bus.data_out !== 8'h99) begin n_fail++; $display("FAIL rm_pre_data_out: got %h want 99", bus.data_out); end
        idle_cycle();
        @(negedge clk);
        bus.mem_rd = 1'b1; bus.addr = 5'h07;
        @(negedge clk); #1;
        n_checks++; if (bus.bus_req !== 1'b1) begin n_fail++; $display("FAIL rm_req_wait1: got %b want 1", bus.bus_req); end
        @(negedge clk);
        rst_ = 1'b0; bus.bus_ack = 1'b1; bus.bus_rdata = 8'hEE;
        #1;
        n_checks++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL rm_req_async_clear: got %b want 0", bus.bus_req); end
        @(negedge clk);
        bus.mem_rd = 1'b0; bus.bus_ack = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        n_checks++; if (bus.cpu_en !== 1'b1) begin n_fail++; $display("FAIL rm_cpu_en: got %b want 1", bus.cpu_en); end
        n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL rm_data_out: got %h want 00", bus.data_out); end
        run_txn(1'b1, 1'b0, 5'h0A, 8'h00, 2, 8'h42, 20, en_low, req_hi, sa, swe, swd, stb, dn);
        n_checks++; if (dn !== 1'b1 || req_hi != 2 || en_low != 3) begin n_fail++; $display("FAIL rm_new_read_timing: done %b req %0d en_low %0d want 1 2 3", dn, req_hi, en_low); end
        n_checks++; if (sa !== 5'h0A) begin n_fail++; $display("FAIL rm_new_read_addr: got %h want 0a", sa); end
        n_checks++; if (bus.data_out !== 8'h42) begin n_fail++; $display("FAIL rm_new_read_data: got %h want 42", bus.data_out); end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_ack_outside_req();
        test_held_strobe();
        test_protocol_error();
        test_timeout();
        test_reset_mid_txn();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_bus_ctl.md
Name: mem_bus_ctl

Overview:
- Memory-side stage directly downstream of the CPU controller.
- Converts the controller's level-style mem_rd/mem_wr strobes into a request/acknowledge bus transaction toward external memory.
- Freezes the CPU with cpu_en while a transaction is in flight, latches read data for the IR/ALU, and detects bus timeouts and protocol errors.

Parameters:
- AW, 5, address width (matches CPU address bus).
- DW, 8, data width.
- TIMEOUT, 16, maximum REQ cycles without bus_ack before error; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst_  in  1  asynchronous active-low reset
- mem_rd  in  1  read strobe from controller, level
- mem_wr  in  1  write strobe from controller, level
- addr  in  AW  CPU address (PC or IR operand, already muxed)
- wdata  in  DW  accumulator write data
- cpu_en  out  1  CPU clock enable; 0 freezes controller, PC, IR, AC
- data_out  out  DW  last read data, held until next read completes
- bus_req  out  1  bus request, registered
- bus_we  out  1  1 = write, registered
- bus_addr  out  AW  registered address
- bus_wdata  out  DW  registered write data
- bus_ack  in  1  memory acknowledge, single cycle
- bus_rdata  in  DW  read data, valid with bus_ack
- bus_err  out  1  sticky error flag

Behaviour:
- Reset (rst_ low, async):
  - state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, data_out=0, bus_err=0, wait_cnt=0.
  - Previous-request registers are cleared. cpu_en=1.
- Start detection (IDLE only):
  - req_now = mem_rd | mem_wr.
  - start = req_now & (!req_prev | addr != addr_prev | mem_wr != wr_prev).
  - The prev registers capture mem_rd|mem_wr, addr and mem_wr every cycle.
  - A level held across several controller phases therefore produces exactly one transaction.
- cpu_en is combinational: 1 only when state==IDLE and start==0. It drops in the same cycle start is seen.
- States (mem_state_t): IDLE, REQ, ERR.
- IDLE:
  - On start: latch bus_addr=addr, bus_we=mem_wr, bus_wdata=wdata; set bus_req=1 and wait_cnt=0; go to REQ.
  - If mem_rd & mem_wr both high on start: set bus_err=1, go to ERR, no bus cycle.
- REQ:
  - On bus_ack: bus_req=0. On a read, data_out=bus_rdata. Go to IDLE.
  - Otherwise wait_cnt++. If wait_cnt==TIMEOUT-1 without ack: bus_req=0, bus_err=1, go to ERR.
- ERR: terminal until reset. cpu_en=0, bus_req=0, bus_err=1.
- Latency: an ack in the k-th REQ cycle (k=1 is zero-wait) gives k+1 cycles of cpu_en=0. data_out is valid in the first cycle cpu_en returns to 1.
- bus_ack outside REQ is ignored; data_out is unchanged.
- Bus outputs are stable for the whole REQ interval.
- Write data is sampled at start. The CPU is frozen, so wdata cannot change mid-transaction anyway.
- Reset asserted mid-transaction aborts immediately: bus_req=0 asynchronously, and no data_out update.
- The wait_cnt width is sized to hold TIMEOUT-1 without wrap.

Decomposition:
- Add to the shared typedefs package:
  - mem_state_t enum {IDLE, REQ, ERR}; since IDLE already exists in state_t, name the literals MB_IDLE, MB_REQ, MB_ERR.
  - Constants ADDR_W=5 and DATA_W=8, used as parameter defaults.
- One natural sub-module: mem_req_detect, containing the prev registers and the start comparator. Everything else stays in mem_bus_ctl.

Test Plan:
- Zero-wait read: mem_rd=1, addr=5'h03; memory acks in the first REQ cycle with rdata=8'hA5.
  - Required: cpu_en low for 2 cycles; bus_addr=03, bus_we=0; data_out=A5 when cpu_en returns to 1.
- 3-wait write: mem_wr=1, addr=5'h1F, wdata=8'h3C; ack in the 3rd REQ cycle.
  - Required: bus_req high 3 cycles with bus_we=1 and bus_wdata=3C; cpu_en low 4 cycles; data_out unchanged.
- Held strobe: mem_rd high for 3 controller phases at addr=5'h02, then dropped; later mem_rd at addr=5'h10.
  - Required: exactly two bus_req pulses, addresses 02 then 10.
- Timeout: TIMEOUT=4, read with bus_ack tied low.
  - Required: bus_req drops after 4 REQ cycles; bus_err=1 sticky; cpu_en stays 0 until rst_ pulse.
- Protocol error: mem_rd=mem_wr=1 from IDLE.
  - Required: no bus_req; bus_err=1 on the next edge; state ERR.
- Reset mid-transaction: assert rst_=0 during the 2nd wait cycle.
  - Required: bus_req=0 immediately; after release cpu_en=1, data_out=0, a new read works normally.
